// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF sample feed path.
package spdif_pkg;

  localparam int unsigned SAMPLE_W         = 24;
  localparam int unsigned FRAMES_PER_BLOCK = 192;
  localparam int unsigned FRAME_IDX_W      = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } feed_state_e;

endpackage

// File: rtl/spdif_sample_fifo.sv
// Synchronous stereo-pair FIFO with registered read data; flush clears contents and output.
module spdif_sample_fifo
  import spdif_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  stereo_t       push_data,
  input  logic          pop,
  input  logic          flush,
  input  logic          rd_clr,
  output stereo_t       rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  stereo_t         mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;
  logic [CW-1:0]   count_next;

  always_comb begin
    do_push    = push & ~full;
    do_pop     = pop & ~empty;
    count_next = flush ? '0 : CW'(count + CW'(do_push) - CW'(do_pop));
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
      if (flush) begin
        wptr    <= '0;
        rptr    <= '0;
        rd_data <= '0;
      end else begin
        if (do_push) begin
          wptr <= AW'(wptr + AW'(1));
        end
        if (do_pop) begin
          rd_data <= mem[rptr];
          rptr    <= AW'(rptr + AW'(1));
        end else if (rd_clr) begin
          rd_data <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/spdif_feed_ctrl.sv
// Feeds buffered stereo pairs to the S/PDIF transmitter, one pair per data request.
// Define SPDIF_FEED_HOLD_LAST_EN to repeat the last pair on underrun instead of muting.
module spdif_feed_ctrl
  import spdif_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned PRIME_LEVEL    = 4,
  parameter int unsigned UNDERRUN_LIMIT = 4,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned FILL_W        = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SAMPLE_W-1:0]    in_left,
  input  logic [SAMPLE_W-1:0]    in_right,
  input  logic                   datareq,
  output logic [SAMPLE_W-1:0]    ldata,
  output logic [SAMPLE_W-1:0]    rdata,
  output logic [FRAME_IDX_W-1:0] frame_idx,
  output logic                   block_start,
  output logic                   underrun,
  output logic [CNT_W-1:0]       underrun_count,
  output logic [FILL_W-1:0]      fill,
  output logic                   running
);

  localparam int unsigned CONSEC_W = $clog2(UNDERRUN_LIMIT + 1);
  localparam logic [FRAME_IDX_W-1:0] LAST_FRAME = FRAME_IDX_W'(FRAMES_PER_BLOCK - 1);
`ifdef SPDIF_FEED_HOLD_LAST_EN
  localparam bit HOLD_LAST = 1'b1;
`else
  localparam bit HOLD_LAST = 1'b0;
`endif

  feed_state_e         state;
  feed_state_e         state_next;
  logic                datareq_d;
  logic [CONSEC_W-1:0] consec;
  logic [CONSEC_W-1:0] consec_next;
  logic                req_c;
  logic                push_c;
  logic                pop_c;
  logic                flush_c;
  logic                rd_clr_c;
  logic                advance_c;
  logic                underrun_c;
  logic [FILL_W-1:0]   fill_next;
  logic                fifo_full;
  logic                fifo_empty;
  stereo_t             rd_data;

  assign req_c   = datareq & ~datareq_d;
  assign push_c  = in_valid & in_ready & ~fifo_full;
  assign ldata   = rd_data.left;
  assign rdata   = rd_data.right;
  assign running = (state == RUN);

  spdif_sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_c),
    .push_data({in_left, in_right}),
    .pop      (pop_c),
    .flush    (flush_c),
    .rd_clr   (rd_clr_c),
    .rd_data  (rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fill)
  );

  always_comb begin
    state_next  = state;
    consec_next = consec;
    pop_c       = 1'b0;
    flush_c     = 1'b0;
    rd_clr_c    = 1'b0;
    advance_c   = 1'b0;
    underrun_c  = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      flush_c    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          flush_c    = 1'b1;
          state_next = PRIME;
        end
        PRIME: begin
          rd_clr_c  = req_c;
          advance_c = req_c;
          if (fill >= FILL_W'(PRIME_LEVEL)) begin
            state_next  = RUN;
            consec_next = '0;
          end
        end
        RUN: begin
          if (req_c) begin
            advance_c = 1'b1;
            if (!fifo_empty) begin
              pop_c       = 1'b1;
              consec_next = '0;
            end else begin
              underrun_c  = 1'b1;
              rd_clr_c    = ~HOLD_LAST;
              consec_next = CONSEC_W'(consec + CONSEC_W'(1));
              if (consec_next >= CONSEC_W'(UNDERRUN_LIMIT)) begin
                state_next = PRIME;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
    // Occupancy after this edge, so in_ready never lags a fill change.
    fill_next = flush_c ? '0 : FILL_W'(fill + FILL_W'(push_c) - FILL_W'(pop_c));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      datareq_d      <= 1'b0;
      consec         <= '0;
      in_ready       <= 1'b0;
      frame_idx      <= LAST_FRAME;
      block_start    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      state       <= state_next;
      datareq_d   <= datareq;
      consec      <= consec_next;
      in_ready    <= (state_next != IDLE) && (fill_next != FILL_W'(DEPTH));
      underrun    <= underrun_c;
      block_start <= advance_c && (frame_idx == LAST_FRAME);
      if (state_next == IDLE) begin
        frame_idx <= LAST_FRAME;
      end else if (advance_c) begin
        frame_idx <= (frame_idx == LAST_FRAME) ? '0 : FRAME_IDX_W'(frame_idx + FRAME_IDX_W'(1));
      end
      if (underrun_c && (underrun_count != '1)) begin
        underrun_count <= CNT_W'(underrun_count + CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_spdif_feed_ctrl.sv
// Self-checking bench for spdif_feed_ctrl against a queue-based behavioural model.
module tb_spdif_feed_ctrl;

  localparam int DEPTH = 8;
  localparam int PRIME_LEVEL = 4;
  localparam int LIMIT = 4;
`ifdef SPDIF_FEED_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_left = '0;
  logic [23:0] in_right = '0;
  logic        datareq = 1'b0;
  logic [23:0] ldata;
  logic [23:0] rdata;
  logic [7:0]  frame_idx;
  logic        block_start;
  logic        underrun;
  logic [15:0] underrun_count;
  logic [3:0]  fill;
  logic        running;

  int total = 0;
  int bad = 0;

  spdif_feed_ctrl #(
    .DEPTH(DEPTH), .PRIME_LEVEL(PRIME_LEVEL), .UNDERRUN_LIMIT(LIMIT), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .datareq(datareq), .ldata(ldata), .rdata(rdata),
    .frame_idx(frame_idx), .block_start(block_start), .underrun(underrun),
    .underrun_count(underrun_count), .fill(fill), .running(running)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=idle, 1=priming, 2=playing
  int          m_mode;
  logic [47:0] m_q[$];
  logic [23:0] m_l, m_r;
  int          m_fidx, m_urc, m_consec;
  bit          m_bs, m_ur, m_ready, m_dq_d;

  task automatic model_reset();
    m_mode = 0; m_q.delete(); m_l = 0; m_r = 0; m_fidx = 191; m_urc = 0; m_consec = 0;
    m_bs = 0; m_ur = 0; m_ready = 0; m_dq_d = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input logic [23:0] l, input logic [23:0] r,
                            input bit dq);
    bit req, push;
    logic [47:0] p;
    req = dq && !m_dq_d;
    m_dq_d = dq;
    push = v && m_ready;
    m_bs = 0; m_ur = 0;
    if (!en) begin
      m_q.delete(); m_l = 0; m_r = 0; m_fidx = 191; m_mode = 0; m_ready = 0;
      return;
    end
    if (m_mode == 0) begin
      m_q.delete(); m_mode = 1;
    end else begin
      if (req) begin
        if (m_mode == 2 && m_q.size() > 0) begin
          p = m_q.pop_front(); m_l = p[47:24]; m_r = p[23:0]; m_consec = 0;
        end else if (m_mode == 2) begin
          m_ur = 1; m_consec++;
          if (m_urc < 65535) m_urc++;
          if (!HOLD) begin m_l = 0; m_r = 0; end
        end else begin
          m_l = 0; m_r = 0;
        end
        m_fidx = (m_fidx + 1) % 192;
        m_bs = (m_fidx == 0);
      end
      if (m_mode == 1 && m_q.size() >= PRIME_LEVEL) begin
        m_mode = 2; m_consec = 0;
      end else if (m_mode == 2 && m_consec >= LIMIT) begin
        m_mode = 1;
      end
      if (push) m_q.push_back({l, r});
    end
    m_ready = (m_q.size() < DEPTH);
  endtask

  task automatic step(input bit en, input bit v, input logic [23:0] l, input logic [23:0] r,
                      input bit dq);
    @(negedge clk);
    enable = en; in_valid = v; in_left = l; in_right = r; datareq = dq;
    model_step(en, v, l, r, dq);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_assert();
    @(negedge clk);
    reset = 1; enable = 0; in_valid = 0; datareq = 1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_release();
    @(negedge clk);
    reset = 0;
    model_reset();
    model_step(0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_assert();
    total++; if (ldata !== 0 || rdata !== 0) begin bad++; $display("FAIL reset_data act=%h/%h exp=0/0", ldata, rdata); end
    total++; if (frame_idx !== 8'd191) begin bad++; $display("FAIL reset_fidx act=%0d exp=191", frame_idx); end
    total++; if (fill !== 0 || running !== 0 || in_ready !== 0) begin bad++; $display("FAIL reset_ctl act fill=%0d run=%b rdy=%b exp 0", fill, running, in_ready); end
    total++; if (underrun_count !== 0 || underrun !== 0 || block_start !== 0) begin bad++; $display("FAIL reset_cnt act=%0d/%b/%b exp 0", underrun_count, underrun, block_start); end
    reset_release();
  endtask

  task automatic test_prime();
    int pushed = 0;
    for (int c = 0; c < 20 && pushed < 4; c++) begin
      bit acc;
      acc = m_ready;
      step(1, 1, 24'h000100 * 24'(pushed + 1), 24'h000200 * 24'(pushed + 1), 0);
      if (acc) pushed++;
    end
    repeat (3) step(1, 0, 0, 0, 0);
    total++; if (fill !== 4'd4) begin bad++; $display("FAIL prime_fill act=%0d exp=4", fill); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL prime_running act=%b exp=1", running); end
    total++; if (ldata !== 0) begin bad++; $display("FAIL prime_ldata act=%h exp=0", ldata); end
  endtask

  task automatic test_run_underrun();
    int bs_cnt = 0, ur_cnt = 0;
    logic [23:0] el, er;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, 0, 1);
      if (k < 4) begin el = 24'h000100 * 24'(k + 1); er = 24'h000200 * 24'(k + 1); end
      else if (HOLD) begin el = 24'h000400; er = 24'h000800; end
      else begin el = 0; er = 0; end
      total++; if (ldata !== el || rdata !== er) begin bad++; $display("FAIL run_data k=%0d act=%h/%h exp=%h/%h", k, ldata, rdata, el, er); end
      total++; if (frame_idx !== 8'(k)) begin bad++; $display("FAIL run_fidx k=%0d act=%0d exp=%0d", k, frame_idx, k); end
      total++; if (underrun !== (k >= 4)) begin bad++; $display("FAIL run_underrun k=%0d act=%b exp=%b", k, underrun, k >= 4); end
      total++; if (running !== (k < 7)) begin bad++; $display("FAIL run_running k=%0d act=%b exp=%b", k, running, k < 7); end
      if (block_start) bs_cnt++;
      if (underrun) ur_cnt++;
      for (int c = 0; c < 511; c++) begin
        step(1, 0, 0, 0, c < 255);
        if (block_start) bs_cnt++;
        if (underrun) ur_cnt++;
      end
    end
    total++; if (bs_cnt != 1) begin bad++; $display("FAIL run_bs_count act=%0d exp=1", bs_cnt); end
    total++; if (ur_cnt != 4) begin bad++; $display("FAIL run_ur_pulses act=%0d exp=4", ur_cnt); end
    total++; if (underrun_count !== 16'd4) begin bad++; $display("FAIL run_ur_count act=%0d exp=4", underrun_count); end
  endtask

  task automatic test_full();
    for (int c = 0; c < 40 && m_q.size() < DEPTH; c++) step(1, 1, 24'($urandom), 24'($urandom), 0);
    repeat (3) step(1, 1, 24'($urandom), 24'($urandom), 0);
    total++; if (fill !== 4'd8 || in_ready !== 1'b0) begin bad++; $display("FAIL full_ready act fill=%0d rdy=%b exp 8/0", fill, in_ready); end
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 1, 24'h5A5A5A, 24'hA5A5A5, 1);
    total++; if (fill !== 4'd7) begin bad++; $display("FAIL full_pushpop act=%0d exp=7", fill); end
    for (int k = 0; k < 7; k++) begin
      step(1, 0, 0, 0, 1);
      total++; if (ldata !== m_l || rdata !== m_r) begin bad++; $display("FAIL full_drain k=%0d act=%h/%h exp=%h/%h", k, ldata, rdata, m_l, m_r); end
      step(1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_disable();
    bit dq = 0;
    int urc_before;
    for (int c = 0; c < 2000 && !(m_mode == 2 && m_fidx == 57); c++) begin
      dq = !dq;
      step(1, 1, 24'($urandom), 24'($urandom), dq);
    end
    total++; if (frame_idx !== 8'd57) begin bad++; $display("FAIL dis_reach act=%0d exp=57", frame_idx); end
    urc_before = m_urc;
    step(0, 1, 24'($urandom), 24'($urandom), 0);
    total++; if (fill !== 0 || ldata !== 0 || rdata !== 0) begin bad++; $display("FAIL dis_flush act fill=%0d l=%h r=%h exp 0", fill, ldata, rdata); end
    total++; if (frame_idx !== 8'd191 || running !== 0) begin bad++; $display("FAIL dis_fidx act=%0d run=%b exp=191/0", frame_idx, running); end
    total++; if (underrun_count !== 16'(urc_before)) begin bad++; $display("FAIL dis_urc act=%0d exp=%0d", underrun_count, urc_before); end
  endtask

  task automatic test_wrap();
    int bs_cnt = 0, first = -1, second = -1;
    for (int c = 0; c < 50 && m_mode != 2; c++) step(1, 1, 24'($urandom), 24'($urandom), 0);
    for (int k = 0; k < 384; k++) begin
      step(1, 1, 24'($urandom), 24'($urandom), 1);
      total++; if (ldata !== m_l || block_start !== m_bs) begin bad++; $display("FAIL wrap_req k=%0d act=%h/%b exp=%h/%b", k, ldata, block_start, m_l, m_bs); end
      if (block_start) begin
        bs_cnt++;
        if (first < 0) first = k; else second = k;
      end
      step(1, 1, 24'($urandom), 24'($urandom), 0);
      if (block_start) bs_cnt++;
    end
    total++; if (bs_cnt != 2 || second - first != 192) begin bad++; $display("FAIL wrap_bs act cnt=%0d gap=%0d exp 2/192", bs_cnt, second - first); end
    total++; if (frame_idx !== 8'd191) begin bad++; $display("FAIL wrap_fidx act=%0d exp=191", frame_idx); end
  endtask

  task automatic test_random();
    bit dq = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) dq = !dq;
      step($urandom_range(0, 299) != 0, $urandom_range(0, 9) < 6, 24'($urandom), 24'($urandom), dq);
      total++; if (ldata !== m_l || rdata !== m_r) begin bad++; $display("FAIL rand_data c=%0d act=%h/%h exp=%h/%h", c, ldata, rdata, m_l, m_r); end
      total++; if (fill !== 4'(m_q.size()) || in_ready !== m_ready) begin bad++; $display("FAIL rand_fill c=%0d act=%0d/%b exp=%0d/%b", c, fill, in_ready, m_q.size(), m_ready); end
      total++; if (frame_idx !== 8'(m_fidx) || block_start !== m_bs) begin bad++; $display("FAIL rand_frame c=%0d act=%0d/%b exp=%0d/%b", c, frame_idx, block_start, m_fidx, m_bs); end
      total++; if (underrun !== m_ur || underrun_count !== 16'(m_urc)) begin bad++; $display("FAIL rand_ur c=%0d act=%b/%0d exp=%b/%0d", c, underrun, underrun_count, m_ur, m_urc); end
      total++; if (running !== (m_mode == 2)) begin bad++; $display("FAIL rand_running c=%0d act=%b exp=%b", c, running, m_mode == 2); end
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 60; c++) step(1, 1, 24'($urandom), 24'($urandom), c % 3 == 0);
    reset_assert();
    total++; if (underrun_count !== 0 || fill !== 0 || frame_idx !== 8'd191) begin bad++; $display("FAIL mreset_state act=%0d/%0d/%0d exp 0/0/191", underrun_count, fill, frame_idx); end
    reset_release();
    repeat (4) step(1, 0, 0, 0, 1);
    total++; if (frame_idx !== 8'd191 || ldata !== 0 || underrun !== 0) begin bad++; $display("FAIL mreset_noreq act=%0d/%h/%b exp=191/0/0", frame_idx, ldata, underrun); end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_run_underrun();
    test_full();
    test_disable();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
